// File: rtl/register_file_pkg.sv
// Shared defaults for the register file: data width, entry count and address width.
package register_file_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

endpackage

// File: rtl/register_file_reg_cell.sv
// One register-file entry: WIDTH-bit register with synchronous reset and load enable.
module reg_cell #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_q <= '0;
        else if (i_load)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// Multi-entry register file: two combinational read ports, one synchronous write port,
// optional hardwired-zero entry 0 and optional write-to-read bypass.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr_a,
    output logic [WIDTH-1:0]  o_rd_data_a,
    input  logic [ADDR_W-1:0] i_rd_addr_b,
    output logic [WIDTH-1:0]  o_rd_data_b,
    output logic              o_wr_err
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic                        w_wr_in_range;
    logic                        w_wr_ok;
    logic [DEPTH-1:0]            w_load;
    logic [DEPTH-1:0][WIDTH-1:0] w_q;
    logic                        r_wr_err;

    assign w_wr_in_range = ({1'b0, i_wr_addr} < DEPTH_L);
    assign w_wr_ok       = i_wr_en && !i_reset && w_wr_in_range;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        localparam int GI = g;
        localparam logic [ADDR_W-1:0] G_ADDR = GI[ADDR_W-1:0];
        localparam bit G_HARD_ZERO = (ZERO_REG != 0) && (GI == 0);

        assign w_load[g] = w_wr_ok && (i_wr_addr == G_ADDR) && !G_HARD_ZERO;

        reg_cell #(.WIDTH(WIDTH)) u_cell (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_load  (w_load[g]),
            .i_d     (i_wr_data),
            .o_q     (w_q[g])
        );
    end

    // Priority: hard zero / out of range, then bypass, then stored value.
    function automatic logic [WIDTH-1:0] rd_mux(
        input logic [ADDR_W-1:0]            a,
        input logic [DEPTH-1:0][WIDTH-1:0]  q,
        input logic                         wr_ok,
        input logic [ADDR_W-1:0]            wr_addr,
        input logic [WIDTH-1:0]             wr_data
    );
        logic [WIDTH-1:0] v;
        v = '0;
        if ({1'b0, a} < DEPTH_L) begin
            v = q[a];
            if (BYPASS != 0 && wr_ok && wr_addr == a)
                v = wr_data;
            if (ZERO_REG != 0 && a == '0)
                v = '0;
        end
        return v;
    endfunction

    always_comb begin
        o_rd_data_a = rd_mux(i_rd_addr_a, w_q, w_wr_ok, i_wr_addr, i_wr_data);
        o_rd_data_b = rd_mux(i_rd_addr_b, w_q, w_wr_ok, i_wr_addr, i_wr_data);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_wr_err <= 1'b0;
        else
            r_wr_err <= i_wr_en && !w_wr_in_range;
    end

    assign o_wr_err = r_wr_err;

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: two instances (bypass/full-depth and no-bypass/zero-reg/depth-6)
// driven from the same stimulus, checked against a behavioural array model via a queue.
module tb_register_file;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [2:0]  i_wr_addr = '0;
    logic [15:0] i_wr_data = '0;
    logic [2:0]  i_rd_addr_a = '0;
    logic [2:0]  i_rd_addr_b = '0;
    logic [15:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic        err0, err1;

    always #5 i_clk = ~i_clk;

    register_file #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_rd_addr_a(i_rd_addr_a), .o_rd_data_a(rd_a0),
        .i_rd_addr_b(i_rd_addr_b), .o_rd_data_b(rd_b0), .o_wr_err(err0));

    register_file #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_rd_addr_a(i_rd_addr_a), .o_rd_data_a(rd_a1),
        .i_rd_addr_b(i_rd_addr_b), .o_rd_data_b(rd_b1), .o_wr_err(err1));

    typedef struct {
        string       tag;
        logic [15:0] a0, b0, a1, b1;
        logic        e0, e1;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m0[8];
    logic [15:0] m1[8];
    logic        me0 = 1'b0, me1 = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [15:0] exp_rd(input int k, input logic [2:0] a);
        int d;
        d = (k == 0) ? 8 : 6;
        if (k == 1 && a == 3'd0) return 16'h0000;
        if (int'(a) >= d) return 16'h0000;
        if (k == 0 && i_wr_en && !i_reset && i_wr_addr == a) return i_wr_data;
        return (k == 0) ? m0[a] : m1[a];
    endfunction

    task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [2:0] ra, input logic [2:0] rb,
                       input bit chk, input string tag);
        exp_t s;
        @(negedge i_clk);
        i_reset = rst; i_wr_en = we; i_wr_addr = wa; i_wr_data = wd;
        i_rd_addr_a = ra; i_rd_addr_b = rb;
        if (chk) begin
            sb.push_back('{tag, exp_rd(0, ra), exp_rd(0, rb), exp_rd(1, ra), exp_rd(1, rb), me0, me1});
            #1;
            s = sb.pop_front();
            chk16({s.tag, " u0.a"}, rd_a0, s.a0);
            chk16({s.tag, " u0.b"}, rd_b0, s.b0);
            chk16({s.tag, " u1.a"}, rd_a1, s.a1);
            chk16({s.tag, " u1.b"}, rd_b1, s.b1);
            chk1({s.tag, " u0.err"}, err0, s.e0);
            chk1({s.tag, " u1.err"}, err1, s.e1);
        end
        @(posedge i_clk);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin m0[i] = '0; m1[i] = '0; end
            me0 = 1'b0; me1 = 1'b0;
        end else begin
            me0 = 1'b0;
            me1 = we && (wa >= 3'd6);
            if (we) m0[wa] = wd;
            if (we && wa < 3'd6 && wa != 3'd0) m1[wa] = wd;
        end
    endtask

    initial begin
        logic [31:0] r;
        // Reset first; outputs are undefined until it lands.
        cyc(1'b1, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, "rst");
        for (int i = 0; i < 8; i += 2)
            cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(i + 1), 1'b1, "post_rst");

        // Same-cycle read shows bypass on u0, old value on u1; next cycle both see it.
        cyc(1'b0, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 1'b1, "beef_same");
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd3, 3'd1, 1'b1, "beef_next");

        // Entry 0: normal on u0, hardwired zero on u1.
        cyc(1'b0, 1'b1, 3'd0, 16'h1234, 3'd0, 3'd0, 1'b1, "zero_same");
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd0, 3'd3, 1'b1, "zero_next");

        // Address 7 is out of range on u1 only: err pulses one cycle.
        cyc(1'b0, 1'b1, 3'd7, 16'hAAAA, 3'd3, 3'd7, 1'b1, "oor_wr");
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd6, 1'b1, "oor_err");
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd7, 3'd3, 1'b1, "oor_clr");
        for (int i = 0; i < 8; i += 2)
            cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(i + 1), 1'b1, "oor_scan");

        // Reset beats a same-cycle write; bypass is suppressed during reset.
        cyc(1'b0, 1'b1, 3'd7, 16'h7777, 3'd7, 3'd7, 1'b1, "pre_rst_oor");
        cyc(1'b1, 1'b1, 3'd2, 16'h5555, 3'd2, 3'd2, 1'b1, "rst_wr");
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd2, 3'd7, 1'b1, "rst_wr_after");

        // Back-to-back writes to one address, then reset mid-stream.
        cyc(1'b0, 1'b1, 3'd1, 16'h1111, 3'd1, 3'd4, 1'b1, "wr1");
        cyc(1'b0, 1'b1, 3'd1, 16'h2222, 3'd1, 3'd4, 1'b1, "wr2");
        cyc(1'b0, 1'b1, 3'd4, 16'h4444, 3'd1, 3'd4, 1'b1, "wr3");
        cyc(1'b0, 1'b1, 3'd5, 16'h5A5A, 3'd1, 3'd5, 1'b1, "wr4");
        cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'd4, 3'd5, 1'b1, "wr_last");
        cyc(1'b1, 1'b0, 3'd0, 16'h0, 3'd1, 3'd4, 1'b1, "mid_rst");
        for (int i = 0; i < 8; i += 2)
            cyc(1'b0, 1'b0, 3'd0, 16'h0, 3'(i), 3'(i + 1), 1'b1, "mid_rst_scan");

        // Random regression on both ports every cycle.
        for (int n = 0; n < 1000; n++) begin
            r = $urandom;
            cyc(($urandom_range(0, 63) == 0), r[16], r[19:17], r[15:0],
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
